// File: rtl/order_scheduler_if.sv
// Order scheduler handshake bundle.
//   req  : one-clk order pulse per menu (bit0 chicken set, bit1 ham set, bit2 combo)
//   ack  : one-clk pulse when a menu's order is dispatched to the cooking units
//   done : one-clk pulse when a menu's order has finished
//   ovr  : one-clk pulse when a req hits a menu that already holds an order
//   GN   : chicken unit busy
//   RD   : ham unit busy
//   YL   : drink unit busy
// The master side issues orders and watches status; the slave is the scheduler.
interface order_scheduler_if;
    logic [2:0] req;
    logic [2:0] ack;
    logic [2:0] done;
    logic [2:0] ovr;
    logic       GN;
    logic       RD;
    logic       YL;

    modport master (output req, input ack, done, ovr, GN, RD, YL);
    modport slave  (input req, output ack, done, ovr, GN, RD, YL);
endinterface

// File: rtl/order_scheduler.sv
// Order scheduler: accepts one order per menu, dispatches pending orders onto
// three shared cooking units (chicken, ham, drink) whose busy time is tracked by
// 3-bit down-counters advancing on tick, and reports dispatch/finish/overrun.
//
// Ports:
//   clk  : system clock, rising edge
//   SW3  : synchronous active-low reset
//   tick : one-clk enable; unit timers count down only on it
//   bus  : order_scheduler_if.slave (req in; ack/done/ovr/GN/RD/YL out)
//
// Build option: define ORDER_SCHED_RR_EN for round-robin arbitration between
// menus; otherwise menu0 > menu1 > menu2 fixed priority with no pointer state.
//
// Per-menu order state:
//   state      | meaning
//   -----------+---------------------------------------------------------
//   ST_EMPTY   | no order held for this menu
//   ST_PENDING | order accepted, waiting for all its recipe units to be free
//   ST_RUNNING | recipe timers loaded; waits until every unit it still owns is 0
module order_scheduler #(
    parameter int unsigned T_CHK  = 5,
    parameter int unsigned T_HAM  = 6,
    parameter int unsigned T_HAM2 = 3,
    parameter int unsigned T_DRK  = 2
) (
    input  logic             clk,
    input  logic             SW3,
    input  logic             tick,
    order_scheduler_if.slave bus
);

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_PENDING = 2'd1,
        ST_RUNNING = 2'd2
    } order_state_t;

    localparam logic [2:0] LD_CHK   = 3'(T_CHK);
    localparam logic [2:0] LD_HAM   = 3'(T_HAM);
    localparam logic [2:0] LD_HAM2  = 3'(T_HAM2);
    localparam logic [2:0] LD_DRK   = 3'(T_DRK);
    localparam logic [1:0] NO_OWNER = 2'd3;

    // unit index: 0 chicken, 1 ham, 2 drink
    function automatic logic [2:0] recipe_mask(input int m);
        case (m)
            0:       recipe_mask = 3'b101;
            1:       recipe_mask = 3'b010;
            default: recipe_mask = 3'b111;
        endcase
    endfunction

    function automatic logic [2:0] recipe_time(input int m, input int u);
        case (u)
            0:       recipe_time = LD_CHK;
            1:       recipe_time = (m == 1) ? LD_HAM : LD_HAM2;
            default: recipe_time = LD_DRK;
        endcase
    endfunction

    function automatic logic [2:0] first_one(input logic [2:0] x);
        if (x[0])      first_one = 3'b001;
        else if (x[1]) first_one = 3'b010;
        else if (x[2]) first_one = 3'b100;
        else           first_one = 3'b000;
    endfunction

    order_state_t st_q [3];
    order_state_t st_d [3];
    logic [2:0]   tmr_q [3];
    logic [2:0]   tmr_d [3];
    logic [1:0]   own_q [3];
    logic [1:0]   own_d [3];
    logic [2:0]   unit_free;
    logic [2:0]   fit;
    logic [2:0]   finish;
    logic [2:0]   gnt;
    logic [2:0]   ack_d;
    logic [2:0]   done_d;
    logic [2:0]   ovr_d;

    always_comb begin
        unit_free = '0;
        for (int u = 0; u < 3; u++) begin
            unit_free[u] = (tmr_q[u] == 3'd0);
        end
    end

    // A running menu finishes once every unit it still owns has drained. Units
    // it no longer owns (regranted after draining early) do not hold it back.
    always_comb begin
        fit    = '0;
        finish = '0;
        for (int m = 0; m < 3; m++) begin
            fit[m]    = (st_q[m] == ST_PENDING) &&
                        ((recipe_mask(m) & ~unit_free) == 3'b000);
            finish[m] = (st_q[m] == ST_RUNNING);
            for (int u = 0; u < 3; u++) begin
                if (own_q[u] == 2'(m) && !unit_free[u]) begin
                    finish[m] = 1'b0;
                end
            end
        end
    end

`ifdef ORDER_SCHED_RR_EN
    // ptr_q is the menu with highest priority this cycle. The candidate vector
    // is rotated so that bit 0 is the pointed menu, picked, then rotated back.
    logic [1:0] ptr_q;
    logic [2:0] fit_r;
    logic [2:0] pick_r;

    always_comb begin
        case (ptr_q)
            2'd1:    fit_r = {fit[0], fit[2], fit[1]};
            2'd2:    fit_r = {fit[1], fit[0], fit[2]};
            default: fit_r = fit;
        endcase
        pick_r = first_one(fit_r);
        case (ptr_q)
            2'd1:    gnt = {pick_r[1], pick_r[0], pick_r[2]};
            2'd2:    gnt = {pick_r[0], pick_r[2], pick_r[1]};
            default: gnt = pick_r;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!SW3) begin
            ptr_q <= 2'd0;
        end else if (gnt[0]) begin
            ptr_q <= 2'd1;
        end else if (gnt[1]) begin
            ptr_q <= 2'd2;
        end else if (gnt[2]) begin
            ptr_q <= 2'd0;
        end
    end
`else
    always_comb begin
        gnt = first_one(fit);
    end
`endif

    // FSM: state register
    always_ff @(posedge clk) begin
        for (int m = 0; m < 3; m++) begin
            if (!SW3) begin
                st_q[m] <= ST_EMPTY;
            end else begin
                st_q[m] <= st_d[m];
            end
        end
    end

    // FSM: next state
    always_comb begin
        for (int m = 0; m < 3; m++) begin
            st_d[m] = st_q[m];
            case (st_q[m])
                ST_EMPTY:   if (bus.req[m]) st_d[m] = ST_PENDING;
                ST_PENDING: if (gnt[m])     st_d[m] = ST_RUNNING;
                ST_RUNNING: if (finish[m])  st_d[m] = ST_EMPTY;
                default:    st_d[m] = ST_EMPTY;
            endcase
        end
    end

    // FSM: outputs (registered below, so they appear one clk after the event)
    always_comb begin
        ack_d  = gnt;
        done_d = finish;
        ovr_d  = '0;
        for (int m = 0; m < 3; m++) begin
            ovr_d[m] = bus.req[m] && (st_q[m] != ST_EMPTY);
        end
    end

    // Unit timers and owners; a load on grant overrides the tick decrement.
    always_comb begin
        for (int u = 0; u < 3; u++) begin
            tmr_d[u] = (tick && tmr_q[u] != 3'd0) ? tmr_q[u] - 3'd1 : tmr_q[u];
            own_d[u] = own_q[u];
        end
        for (int m = 0; m < 3; m++) begin
            if (gnt[m]) begin
                for (int u = 0; u < 3; u++) begin
                    if (recipe_mask(m)[u]) begin
                        tmr_d[u] = recipe_time(m, u);
                        own_d[u] = 2'(m);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!SW3) begin
            for (int u = 0; u < 3; u++) begin
                tmr_q[u] <= 3'd0;
                own_q[u] <= NO_OWNER;
            end
            bus.ack  <= 3'b000;
            bus.done <= 3'b000;
            bus.ovr  <= 3'b000;
            bus.GN   <= 1'b0;
            bus.RD   <= 1'b0;
            bus.YL   <= 1'b0;
        end else begin
            for (int u = 0; u < 3; u++) begin
                tmr_q[u] <= tmr_d[u];
                own_q[u] <= own_d[u];
            end
            bus.ack  <= ack_d;
            bus.done <= done_d;
            bus.ovr  <= ovr_d;
            bus.GN   <= (tmr_d[0] != 3'd0);
            bus.RD   <= (tmr_d[1] != 3'd0);
            bus.YL   <= (tmr_d[2] != 3'd0);
        end
    end

endmodule
